// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin arbiter and sequencer that shares one
// registered AND/OR/XOR/ADD unit between two valid/ready requesters.
// Each operation runs IDLE (accept) -> EXEC (compute) -> RESP (hold until
// the consumer accepts it).
// Optional feature: define ALU_PARITY_EN to add a registered Parity output
// (XOR-reduction of Result).
module alu_share_arbiter #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             ReqValid0,
  output logic             ReqReady0,
  input  logic [1:0]       ReqOp0,
  input  logic [WIDTH-1:0] ReqA0,
  input  logic [WIDTH-1:0] ReqB0,
  input  logic             ReqValid1,
  output logic             ReqReady1,
  input  logic [1:0]       ReqOp1,
  input  logic [WIDTH-1:0] ReqA1,
  input  logic [WIDTH-1:0] ReqB1,
  output logic             RespValid,
  input  logic             RespReady,
  output logic             RespId,
  output logic [WIDTH-1:0] Result,
  output logic             Cout,
  output logic             Zero,
  output logic             Busy
`ifdef ALU_PARITY_EN
  ,
  output logic             Parity
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_ADD = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
`ifdef ALU_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic             any_valid;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic [WIDTH:0]   alu_sum;

  // Grant selection: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    any_valid = ReqValid0 | ReqValid1;
    grant_id  = (ReqValid0 && ReqValid1) ? ~last_grant_q : ReqValid1;
    accept    = (state_q == IDLE) && any_valid;
    ReqReady0 = accept && !grant_id;
    ReqReady1 = accept && grant_id;
  end

  // Shared ALU datapath on the latched operands; ADD keeps the carry as bit WIDTH.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and a latch is inferred.
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_sum  = {1'b0, a_q} + {1'b0, b_q};
    unique case (op_q)
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_ADD: begin
        alu_res  = alu_sum[WIDTH-1:0];
        alu_cout = alu_sum[WIDTH];
      end
    endcase
  end

  // Next-state and next-register values for the IDLE/EXEC/RESP sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    result_d     = result_q;
    cout_d       = cout_q;
    zero_d       = zero_q;
`ifdef ALU_PARITY_EN
    parity_d     = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d         = grant_id ? op_t'(ReqOp1) : op_t'(ReqOp0);
          a_d          = grant_id ? ReqA1 : ReqA0;
          b_d          = grant_id ? ReqB1 : ReqB0;
          id_d         = grant_id;
          last_grant_d = grant_id;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_res;
        cout_d   = alu_cout;
        zero_d   = (alu_res == '0);
`ifdef ALU_PARITY_EN
        parity_d = ^alu_res;
`endif
        state_d  = RESP;
      end
      RESP: begin
        if (RespReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, latched request and registered result; reset aborts any operation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= OP_AND;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      result_q     <= '0;
      cout_q       <= 1'b0;
      zero_q       <= 1'b0;
`ifdef ALU_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      result_q     <= result_d;
      cout_q       <= cout_d;
      zero_q       <= zero_d;
`ifdef ALU_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Status and result outputs are taken straight from registers.
  always_comb begin
    RespValid = (state_q == RESP);
    Busy      = (state_q != IDLE);
    RespId    = id_q;
    Result    = result_q;
    Cout      = cout_q;
    Zero      = zero_q;
`ifdef ALU_PARITY_EN
    Parity    = parity_q;
`endif
  end

endmodule
